// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer for the five-stage pipeline.
// Owns HI/LO. mult/div/madd results are computed at the issue edge into
// pending registers. A busy counter then holds them back for the fixed
// latency before they are committed to HI/LO.
// Optional feature macro: MDU_MADD_EN (accept madd/maddu/msub/msubu).
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hl_out
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t       state_q, state_n;
    logic [3:0]   cnt_q, cnt_n;
    logic         busy_q;
    logic [31:0]  hi_q, lo_q, pend_hi, pend_lo;
    logic         is_mul, is_div, is_madd, is_long, op_signed;
    logic         take, commit;

    logic signed [32:0] a33, b33, den33, quot33, rem33;
    logic signed [63:0] a64, b64, prod;
    logic        [63:0] hilo, res;
    logic               unused_div;

    // Decode the E-stage op into long-latency classes and signedness
    always_comb begin
        is_mul    = (op_E == 4'd1) || (op_E == 4'd2);
        is_div    = (op_E == 4'd3) || (op_E == 4'd4);
`ifdef MDU_MADD_EN
        is_madd   = (op_E >= 4'd9) && (op_E <= 4'd12);
`else
        is_madd   = 1'b0;
`endif
        is_long   = is_mul | is_div | is_madd;
        op_signed = (op_E == 4'd1) || (op_E == 4'd3) ||
                    (op_E == 4'd9) || (op_E == 4'd11);
    end

    // One 33-bit signed datapath serves both signed and unsigned ops: the
    // extra bit is the sign for signed ops and zero otherwise. It also keeps
    // 0x80000000 / -1 well defined, wrapping back to 0x80000000.
    assign a33   = {op_signed & rs_E[31], rs_E};
    assign b33   = {op_signed & rt_E[31], rt_E};
    assign a64   = {{31{a33[32]}}, a33};
    assign b64   = {{31{b33[32]}}, b33};
    assign prod  = a64 * b64;
    assign den33 = (rt_E == 32'd0) ? 33'sd1 : b33;
    assign quot33 = a33 / den33;
    assign rem33  = a33 % den33;
    assign unused_div = quot33[32] ^ rem33[32];
    assign hilo  = {hi_q, lo_q};

    // Select the 64-bit {hi,lo} value the issued op will commit
    always_comb begin
        res = hilo;
        if (is_mul)
            res = prod;
        else if (is_div)
            res = (rt_E == 32'd0) ? hilo : {rem33[31:0], quot33[31:0]};
`ifdef MDU_MADD_EN
        else if (is_madd)
            res = ((op_E == 4'd11) || (op_E == 4'd12)) ? hilo - prod : hilo + prod;
`endif
    end

    // Next-state logic: launch from IDLE, count down in BUSY, commit at 1
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        take    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && is_long) begin
                    take    = 1'b1;
                    cnt_n   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd1) begin
                    commit  = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Control state, counter and registered busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            busy_q  <= (state_n == S_BUSY);
        end
    end

    // Pending result captured at the issue edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (take) begin
            {pend_hi, pend_lo} <= res;
        end
    end

    // HI/LO: commit at the end of the busy window; mthi/mtlo write only when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (commit) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
        end else if (state_q == S_IDLE && start) begin
            if (op_E == 4'd5) hi_q <= rs_E;
            if (op_E == 4'd6) lo_q <= rs_E;
        end
    end

    assign busy   = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign stall  = md_use_D & (busy_q | (start & is_long));
    assign hl_out = (op_E == 4'd7) ? hi_q :
                    (op_E == 4'd8) ? lo_q : 32'd0;

endmodule
